uart_tx_frame_ctrl: RTL and testbench

//  - Transmit-side UART frame sequencer: accepts one byte on a start strobe,

---
 rtl/uart_tx_frame_ctrl_pkg.sv | 19 +
 rtl/uart_tx_frame_ctrl_parity.sv | 20 ++
 rtl/uart_tx_frame_ctrl.sv | 116 +++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_frame_ctrl_pkg.sv
// Shared definitions for the UART transmit frame sequencer: FSM states,
// parity selection codes and serial line levels.
package uart_tx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic EVEN  = 1'b0;
  localparam logic ODD   = 1'b1;

  localparam logic MARK  = 1'b1;
  localparam logic SPACE = 1'b0;

endpackage

// File: rtl/uart_tx_frame_ctrl_parity.sv
// Parity_Selector: produces the parity bit for one byte, even or odd.
// The returned bit makes the total number of ones (data + parity) match the selection.
module Parity_Selector
  import uart_tx_frame_ctrl_pkg::*;
(
  input  logic [7:0] data_in,
  input  logic       parity_sel,
  output logic       parity_out
);

  always_comb begin
    parity_out = ^data_in;
    case (parity_sel)
      EVEN:    parity_out = ^data_in;
      ODD:     parity_out = ~^data_in;
      default: parity_out = ^data_in;
    endcase
  end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame sequencer: start bit, LSB-first data, optional parity,
// one or two stop bits, one bit per baud_clk cycle, all outputs registered.
module uart_tx_frame_ctrl
  import uart_tx_frame_ctrl_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1,
  parameter int STOP_BITS = 1
) (
  input  logic              baud_clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              parity_sel,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BitW = $clog2(DATA_W);
  localparam logic [BitW-1:0] LastBit  = BitW'(DATA_W - 1);
  localparam logic            LastStop = 1'(STOP_BITS - 1);

  tx_state_e         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [BitW-1:0]   bitCnt_q;
  logic              stopCnt_q;
  logic              par_q;
  logic              par_d;
  logic              txOut_q;
  logic              busy_q;
  logic              done_q;

  Parity_Selector u_parity (
    .data_in    (tx_data),
    .parity_sel (parity_sel),
    .parity_out (par_d)
  );

  // Each branch loads the line level for the state being entered, so
  // tx_out always reflects the current state without a combinational path.
  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      stopCnt_q <= 1'b0;
      par_q     <= 1'b0;
      txOut_q   <= MARK;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          txOut_q <= MARK;
          busy_q  <= 1'b0;
          if (tx_start) begin
            shift_q <= tx_data;
            par_q   <= par_d;
            txOut_q <= SPACE;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          state_q  <= DATA;
          bitCnt_q <= '0;
          txOut_q  <= shift_q[0];
          shift_q  <= shift_q >> 1;
        end
        DATA: begin
          if (bitCnt_q == LastBit) begin
            stopCnt_q <= 1'b0;
            if (PARITY_EN != 0) begin
              state_q <= PARITY;
              txOut_q <= par_q;
            end else begin
              state_q <= STOP;
              txOut_q <= MARK;
            end
          end else begin
            bitCnt_q <= bitCnt_q + BitW'(1);
            txOut_q  <= shift_q[0];
            shift_q  <= shift_q >> 1;
          end
        end
        PARITY: begin
          state_q   <= STOP;
          stopCnt_q <= 1'b0;
          txOut_q   <= MARK;
        end
        STOP: begin
          txOut_q <= MARK;
          if (stopCnt_q == LastStop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            stopCnt_q <= stopCnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          txOut_q <= MARK;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_out  = txOut_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl: directed frames plus randomized
// traffic compared against a bit-index reference model of the UART frame.
module tb_uart_tx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start, parity_sel;
  logic [7:0] tx_data;
  logic       tx_out, tx_busy, tx_done;
  logic       start2;
  logic [7:0] data2;
  logic       out2, busy2, done2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_frame_ctrl dut (
    .baud_clk   (clk),
    .rst        (rst),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .parity_sel (parity_sel),
    .tx_out     (tx_out),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  uart_tx_frame_ctrl #(.DATA_W(8), .PARITY_EN(0), .STOP_BITS(2)) dut2 (
    .baud_clk   (clk),
    .rst        (rst),
    .tx_start   (start2),
    .tx_data    (data2),
    .parity_sel (1'b0),
    .tx_out     (out2),
    .tx_busy    (busy2),
    .tx_done    (done2)
  );

  // Reference: value of bit i of a frame, counted from the start bit.
  function automatic logic expBit(input int i, input logic [7:0] d,
                                  input logic sel, input int parEn);
    int ones;
    ones = $countones(d);
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    if (parEn != 0 && i == 9) return sel ? (ones % 2 == 0) : (ones % 2 == 1);
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic sel);
    tx_start   = 1'b1;
    tx_data    = d;
    parity_sel = sel;
  endtask

  task automatic idleCheck();
    @(negedge clk);
    checkOutput("idle_out", tx_out, 1);
    checkOutput("idle_busy", tx_busy, 0);
    checkOutput("idle_done", tx_done, 0);
  endtask

  // Called at the negedge where the start request was driven; returns at
  // the negedge of the tx_done cycle.
  task automatic checkFrame(input logic [7:0] d, input logic sel,
                            input bit hold, input bit noisy);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      checkOutput("bit", tx_out, expBit(i, d, sel, 1));
      checkOutput("busy", tx_busy, 1);
      checkOutput("done_early", tx_done, 0);
      if (!hold) tx_start = 1'b0;
      if (noisy) begin
        if (i == 2) begin
          tx_start = 1'b1;
          tx_data  = 8'hFF;
        end else begin
          tx_start   = 1'($urandom % 2);
          tx_data    = 8'($urandom);
          parity_sel = 1'($urandom % 2);
        end
      end
    end
    @(negedge clk);
    checkOutput("done", tx_done, 1);
    checkOutput("done_busy", tx_busy, 0);
    checkOutput("done_out", tx_out, 1);
    if (!hold) tx_start = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       s;
    int         gap;
    rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00; parity_sel = 1'b0;
    start2 = 1'b0; data2 = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out", tx_out, 1);
    checkOutput("rst_busy", tx_busy, 0);
    checkOutput("rst_done", tx_done, 0);
    rst = 1'b0;
    idleCheck();

    applyStimulus(8'hA5, 1'b0);
    checkFrame(8'hA5, 1'b0, 0, 0);
    idleCheck();

    applyStimulus(8'h07, 1'b1);
    checkFrame(8'h07, 1'b1, 0, 0);
    idleCheck();
    applyStimulus(8'h07, 1'b0);
    checkFrame(8'h07, 1'b0, 0, 0);
    idleCheck();

    applyStimulus(8'h55, 1'b0);
    checkFrame(8'h55, 1'b0, 1, 0);
    tx_data = 8'h0F;
    checkFrame(8'h0F, 1'b0, 1, 0);
    tx_start = 1'b0;
    idleCheck();
    idleCheck();

    applyStimulus(8'h00, 1'b0);
    checkFrame(8'h00, 1'b0, 0, 1);
    repeat (3) idleCheck();

    applyStimulus(8'h3C, 1'b1);
    repeat (5) @(negedge clk);
    tx_start = 1'b0;
    checkOutput("mid_busy", tx_busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("async_out", tx_out, 1);
    checkOutput("async_busy", tx_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    idleCheck();
    applyStimulus(8'hC3, 1'b1);
    checkFrame(8'hC3, 1'b1, 0, 0);
    idleCheck();

    d = 8'($urandom);
    s = 1'($urandom % 2);
    applyStimulus(d, s);
    for (int n = 0; n < 20; n++) begin
      checkFrame(d, s, 0, 1);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) idleCheck();
      d = 8'($urandom);
      s = 1'($urandom % 2);
      applyStimulus(d, s);
    end
    checkFrame(d, s, 0, 0);
    idleCheck();

    start2 = 1'b1;
    data2  = 8'h81;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      start2 = 1'b0;
      checkOutput("np_bit", out2, expBit(i, 8'h81, 1'b0, 0));
      checkOutput("np_busy", busy2, 1);
    end
    @(negedge clk);
    checkOutput("np_done", done2, 1);
    checkOutput("np_done_busy", busy2, 0);
    @(negedge clk);
    checkOutput("np_idle_done", done2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
